// File: rtl/mul_pipe.sv
// mul_pipe: two-stage 32x32 multiplier (E -> M -> W), one op per cycle, results 2 edges after issue.
// No stall and no backpressure. `define MUL_PIPE_MULH_EN selects the MULH/MULHSU/MULHU forms; otherwise rd is always the low word.

module mul_e (
  input  logic [31:0] rs1,
  input  logic [31:0] rs2,
  input  logic [1:0]  mul_op,
  output logic [47:0] pl,
  output logic [47:0] ph,
  output logic        negate
);
  logic        sign_a;
  logic        sign_b;
  logic [31:0] mag_a;
  logic [31:0] mag_b;

  // rs1 is unsigned only for MULHU; rs2 is unsigned for MULHSU and MULHU.
  // Negating 0x80000000 wraps back to 0x80000000, which is the correct magnitude.
  always_comb begin
    sign_a = (mul_op != 2'b11) && rs1[31];
    sign_b = !mul_op[1] && rs2[31];
    mag_a  = sign_a ? (~rs1 + 32'd1) : rs1;
    mag_b  = sign_b ? (~rs2 + 32'd1) : rs2;
    pl     = 48'(mag_a) * 48'(mag_b[15:0]);
    ph     = 48'(mag_a) * 48'(mag_b[31:16]);
    negate = sign_a ^ sign_b;
  end
endmodule

module mul_m (
  input  logic [47:0] pl,
  input  logic [47:0] ph,
  output logic [63:0] p
);
  assign p = {16'h0000, pl} + {ph, 16'h0000};
endmodule

module mul_w (
  input  logic [63:0] p,
  input  logic        negate,
  input  logic [1:0]  mul_op,
  input  logic        valid,
  output logic        out_valid,
  output logic [31:0] rd
);
  logic [63:0] r;

  always_comb begin
    r         = negate ? (~p + 64'd1) : p;
    rd        = (mul_op == 2'b00) ? r[31:0] : r[63:32];
    out_valid = valid;
  end
endmodule

module mul_pipe (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [31:0] rs1,
  input  logic [31:0] rs2,
  input  logic [1:0]  mul_op,
  output logic        out_valid,
  output logic [31:0] rd
);
  typedef struct packed {
    logic        vld;
    logic        neg;
`ifdef MUL_PIPE_MULH_EN
    logic [1:0]  op;
`endif
    logic [47:0] pl;
    logic [47:0] ph;
  } em_t;

  typedef struct packed {
    logic        vld;
    logic        neg;
`ifdef MUL_PIPE_MULH_EN
    logic [1:0]  op;
`endif
    logic [63:0] p;
  } mw_t;

  em_t         em_q;
  mw_t         mw_q;
  logic [47:0] e_pl;
  logic [47:0] e_ph;
  logic        e_neg;
  logic [63:0] m_p;
  logic [1:0]  e_op;
  logic [1:0]  w_op;

`ifdef MUL_PIPE_MULH_EN
  assign e_op = mul_op;
  assign w_op = mw_q.op;
`else
  // Low product word is identical for every signedness, so the op is dropped at the door.
  logic unused_mul_op;
  assign unused_mul_op = ^mul_op;
  assign e_op = 2'b00;
  assign w_op = 2'b00;
`endif

  mul_e u_e (
    .rs1    (rs1),
    .rs2    (rs2),
    .mul_op (e_op),
    .pl     (e_pl),
    .ph     (e_ph),
    .negate (e_neg)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      em_q <= '0;
    end else begin
      em_q.vld <= in_valid;
      em_q.neg <= e_neg;
`ifdef MUL_PIPE_MULH_EN
      em_q.op  <= mul_op;
`endif
      em_q.pl  <= e_pl;
      em_q.ph  <= e_ph;
    end
  end

  mul_m u_m (
    .pl (em_q.pl),
    .ph (em_q.ph),
    .p  (m_p)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mw_q <= '0;
    end else begin
      mw_q.vld <= em_q.vld;
      mw_q.neg <= em_q.neg;
`ifdef MUL_PIPE_MULH_EN
      mw_q.op  <= em_q.op;
`endif
      mw_q.p   <= m_p;
    end
  end

  mul_w u_w (
    .p         (mw_q.p),
    .negate    (mw_q.neg),
    .mul_op    (w_op),
    .valid     (mw_q.vld),
    .out_valid (out_valid),
    .rd        (rd)
  );
endmodule

// File: tb/tb_mul_pipe.sv
// Self-checking bench for mul_pipe: directed corner products, back-to-back issue,
// mid-flight reset and randomized traffic against a 64-bit arithmetic reference.

module tb_mul_pipe;
`ifdef MUL_PIPE_MULH_EN
  localparam bit MULH_EN = 1'b1;
`else
  localparam bit MULH_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [31:0] rs1 = '0;
  logic [31:0] rs2 = '0;
  logic [1:0]  mul_op = '0;
  logic        out_valid;
  logic [31:0] rd;

  int n_vec = 0;
  int n_err = 0;

  // Two-deep model of what will appear on the outputs.
  logic        p1_vld = 1'b0, p2_vld = 1'b0, exp_vld;
  logic [31:0] p1_rd = '0, p2_rd = '0, exp_rd;

  mul_pipe dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .rs1       (rs1),
    .rs2       (rs2),
    .mul_op    (mul_op),
    .out_valid (out_valid),
    .rd        (rd)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ref_rd(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op);
    longint unsigned ea, eb, prod;
    ea   = (op != 2'b11 && a[31]) ? {32'hFFFF_FFFF, a} : {32'h0, a};
    eb   = (op[1] == 1'b0 && b[31]) ? {32'hFFFF_FFFF, b} : {32'h0, b};
    prod = ea * eb;
    if (!MULH_EN || op == 2'b00) return prod[31:0];
    return prod[63:32];
  endfunction

  // Drive one cycle of inputs on the falling edge; exp_* then holds what the outputs must show now.
  task automatic step(input bit v, input logic [31:0] a, input logic [31:0] b, input logic [1:0] op);
    @(negedge clk);
    in_valid = v;
    rs1      = a;
    rs2      = b;
    mul_op   = op;
    exp_vld  = p2_vld;
    exp_rd   = p2_rd;
    p2_vld   = p1_vld;
    p2_rd    = p1_rd;
    p1_vld   = rst ? 1'b0 : v;
    p1_rd    = rst ? 32'h0 : ref_rd(a, b, op);
    #1;
  endtask

  task automatic clear_model();
    p1_vld = 1'b0; p1_rd = '0;
    p2_vld = 1'b0; p2_rd = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clear_model();
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 32'h0, 32'h0, 2'b00);
      n_vec++;
      if (out_valid !== 1'b0 || rd !== 32'h0) begin
        n_err++;
        $display("FAIL reset_hold: out_valid=%b rd=%h, need out_valid=0 rd=00000000", out_valid, rd);
      end
    end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 32'h0, 32'h0, 2'b00);
      n_vec++;
      if (out_valid !== 1'b0 || rd !== 32'h0) begin
        n_err++;
        $display("FAIL reset_idle: out_valid=%b rd=%h, need out_valid=0 rd=00000000", out_valid, rd);
      end
    end
  endtask

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] full;
    logic [31:0] low;
  } vec_t;

  task automatic test_directed();
    vec_t tbl[$];
    int   n;
    tbl.push_back('{2'b00, 32'h0000_0002, 32'h0000_0003, 32'h0000_0006, 32'h0000_0006});
    tbl.push_back('{2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001});
    tbl.push_back('{2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001});
    tbl.push_back('{2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001});
    tbl.push_back('{2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001});
    tbl.push_back('{2'b01, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000});
    tbl.push_back('{2'b10, 32'h8000_0000, 32'h0000_0002, 32'hFFFF_FFFF, 32'h0000_0000});
    tbl.push_back('{2'b01, 32'h0000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0000});
    tbl.push_back('{2'b00, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 32'hFFFF_FFF9});
    tbl.push_back('{2'b11, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 32'h0000_0000});
    tbl.push_back('{2'b00, 32'h0000_0000, 32'h8000_0000, 32'h0000_0000, 32'h0000_0000});
    n = tbl.size();
    for (int i = 0; i < n + 2; i++) begin
      if (i < n) step(1'b1, tbl[i].a, tbl[i].b, tbl[i].op);
      else       step(1'b0, 32'h0, 32'h0, 2'b00);
      n_vec++;
      if (i < 2) begin
        if (out_valid !== 1'b0) begin
          n_err++;
          $display("FAIL directed_early_valid[%0d]: out_valid=%b, need 0", i, out_valid);
        end
      end else begin
        logic [31:0] want;
        want = MULH_EN ? tbl[i-2].full : tbl[i-2].low;
        if (out_valid !== 1'b1 || rd !== want) begin
          n_err++;
          $display("FAIL directed[%0d] op=%b %h*%h: out_valid=%b rd=%h, need out_valid=1 rd=%h",
                   i - 2, tbl[i-2].op, tbl[i-2].a, tbl[i-2].b, out_valid, rd, want);
        end
      end
    end
  endtask

  task automatic test_mid_reset();
    step(1'b0, 32'h0, 32'h0, 2'b00);
    step(1'b0, 32'h0, 32'h0, 2'b00);
    step(1'b1, 32'h0000_0005, 32'h0000_0005, 2'b00);
    @(posedge clk);
    #2;
    rst = 1'b1;
    clear_model();
    #1;
    n_vec++;
    if (out_valid !== 1'b0 || rd !== 32'h0) begin
      n_err++;
      $display("FAIL midreset_async: out_valid=%b rd=%h, need out_valid=0 rd=00000000", out_valid, rd);
    end
    step(1'b0, 32'h0, 32'h0, 2'b00);
    @(negedge clk);
    rst = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 32'h0, 32'h0, 2'b00);
      n_vec++;
      if (out_valid !== 1'b0 || rd !== 32'h0) begin
        n_err++;
        $display("FAIL midreset_leak[%0d]: out_valid=%b rd=%h, need out_valid=0 rd=00000000", i, out_valid, rd);
      end
    end
    step(1'b1, 32'h0000_0006, 32'h0000_0007, 2'b00);
    step(1'b0, 32'h0, 32'h0, 2'b00);
    step(1'b0, 32'h0, 32'h0, 2'b00);
    n_vec++;
    if (out_valid !== 1'b1 || rd !== 32'd42) begin
      n_err++;
      $display("FAIL midreset_next: out_valid=%b rd=%h, need out_valid=1 rd=0000002a", out_valid, rd);
    end
  endtask

  function automatic logic [31:0] pick_operand();
    logic [31:0] edges [5];
    edges = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};
    if ($urandom_range(0, 3) == 0) return edges[$urandom_range(0, 4)];
    return $urandom;
  endfunction

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 3) != 0, pick_operand(), pick_operand(), 2'($urandom_range(0, 3)));
      n_vec++;
      if (out_valid !== exp_vld) begin
        n_err++;
        $display("FAIL random_valid[%0d]: out_valid=%b, need %b", i, out_valid, exp_vld);
      end
      n_vec++;
      if (rd !== exp_rd) begin
        n_err++;
        $display("FAIL random_rd[%0d]: rd=%h, need %h", i, rd, exp_rd);
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_mid_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/mul_pipe.md
MUL_PIPE -- requirements
Module: mul_pipe

Interface
REQ-001 SHALL provide clk  input  1  single clock; all state on its rising edge.
REQ-002 SHALL provide rst  input  1  asynchronous active-high reset.
REQ-003 SHALL provide in_valid  input  1  operands and op valid this cycle.
REQ-004 SHALL provide rs1  input  32  multiplicand.
REQ-005 SHALL provide rs2  input  32  multiplier.
REQ-006 SHALL provide mul_op  input  2  00=MUL, 01=MULH, 10=MULHSU, 11=MULHU.
REQ-007 SHALL provide out_valid  output  1  rd holds a completed result.
REQ-008 SHALL provide rd  output  32  selected result word.

Function
REQ-009 SHALL be built as three stage submodules (E, M, W) plus two pipeline register banks (E->M, M->W) in mul_pipe.
REQ-010 E stage (combinational on inputs) SHALL treat rs1 as signed for MUL/MULH/MULHSU and rs2 as signed for MUL/MULH; else unsigned.
REQ-011 E stage SHALL form 32-bit magnitudes |a|, |b| (0x80000000 signed -> magnitude 0x80000000) and negate = sign_a XOR sign_b, where the sign counts only for operands treated as signed.
REQ-012 E stage SHALL form partials pl = |a| * |b|[15:0] and ph = |a| * |b|[31:16], each 48 bits unsigned.
REQ-013 E->M register SHALL capture pl, ph, negate, mul_op and in_valid every rising edge.
REQ-014 M stage SHALL compute 64-bit unsigned p = pl + (ph << 16).
REQ-015 M->W register SHALL capture p, negate, mul_op and valid every rising edge.
REQ-016 W stage (combinational on the M->W register) SHALL form r = negate ? (~p + 1) mod 2^64 : p.
REQ-017 W stage SHALL drive rd = r[31:0] for MUL, else r[63:32]; out_valid = registered valid.
REQ-018 Latency SHALL be 2 rising edges: inputs valid in cycle N give rd/out_valid in cycle N+2.
REQ-019 Throughput SHALL be one operation per cycle; no stall and no backpressure.
REQ-020 mul_op SHALL travel with its operands; later changes on mul_op never affect in-flight results.
REQ-021 Zero product with negate=1 SHALL yield 0.
REQ-022 in_valid=0 cycles SHALL still propagate data, but out_valid SHALL be 0 for them.

Reset
REQ-023 rst=1 SHALL asynchronously clear both register banks: products 0, negate 0, mul_op 00, valid 0.
REQ-024 During and after reset until new data arrives, out_valid=0 and rd=0x00000000.
REQ-025 Reset mid-operation SHALL discard all in-flight operations; none may emerge afterwards.

Configuration
REQ-026 With macro MUL_PIPE_MULH_EN defined, all four mul_op encodings SHALL be supported as above.
REQ-027 Without MUL_PIPE_MULH_EN, mul_op SHALL be ignored (not pipelined) and rd SHALL always be the low 32 bits of the product (MUL behaviour).

Verification
REQ-028 MUL rs1=2, rs2=3 -> rd=0x00000006, out_valid=1 exactly two edges later.
REQ-029 rs1=rs2=0xFFFFFFFF: MUL -> 0x00000001; MULH -> 0x00000000; MULHU -> 0xFFFFFFFE; MULHSU -> 0xFFFFFFFF.
REQ-030 MULH rs1=rs2=0x80000000 -> 0x40000000; MULHSU rs1=0x80000000, rs2=0x00000002 -> 0xFFFFFFFF.
REQ-031 Back-to-back ops on consecutive cycles (MUL 7*-1, MULHU 0x10000*0x10000, MUL 0*0x80000000) -> 0xFFFFFFF9, 0x00000001, 0x00000000 on three consecutive cycles.
REQ-032 Assert rst between issue and completion of an op -> out_valid stays 0, rd=0; the next op after release completes normally.
REQ-033 Build without MUL_PIPE_MULH_EN, mul_op=11, rs1=rs2=0xFFFFFFFF -> rd=0x00000001.
